// File: rtl/sm4_round_engine_if.sv
// Block handshake between the upstream block source and the SM4 round engine.
//   data_in        : 128-bit input block, X0 in [127:96]
//   data_valid_in  : block offered by the source
//   ready_out      : engine can accept a block this cycle
//   busy_out       : rounds in progress
//   data_out       : result block (X35, X34, X33, X32), MSW first
//   data_valid_out : one-cycle pulse, data_out valid
interface sm4_round_engine_if;
  logic [127:0] data_in;
  logic         data_valid_in;
  logic         ready_out;
  logic         busy_out;
  logic [127:0] data_out;
  logic         data_valid_out;

  modport master (
    output data_in, data_valid_in,
    input  ready_out, busy_out, data_out, data_valid_out
  );

  modport slave (
    input  data_in, data_valid_in,
    output ready_out, busy_out, data_out, data_valid_out
  );
endinterface

// File: rtl/sm4_round_engine.sv
// Iterative SM4 round engine. Takes one 128-bit block per handshake, runs the
// 32 rounds ROUNDS_PER_CYCLE at a time using round keys rk00..rk31 from key
// expansion, and emits the word-reversed result with a one-cycle valid pulse.
// Encrypt/decrypt are the same datapath; key ordering is done upstream.
//   clk                 : clock, rising edge
//   reset_n             : asynchronous active-low reset
//   sm4_enable_in       : global enable; low aborts and idles the engine
//   key_exp_finished_in : round keys valid and stable
//   rk00_in..rk31_in    : round keys, rkNN applied at round NN
//   bus                 : block handshake (slave side)
//
// state   | meaning
// S_IDLE  | waiting for a block; ready_out may be high
// S_ROUND | applying rounds; counter = index of next round to apply
module sm4_round_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sm4_enable_in,
  input  logic        key_exp_finished_in,
  input  logic [31:0] rk00_in, rk01_in, rk02_in, rk03_in,
  input  logic [31:0] rk04_in, rk05_in, rk06_in, rk07_in,
  input  logic [31:0] rk08_in, rk09_in, rk10_in, rk11_in,
  input  logic [31:0] rk12_in, rk13_in, rk14_in, rk15_in,
  input  logic [31:0] rk16_in, rk17_in, rk18_in, rk19_in,
  input  logic [31:0] rk20_in, rk21_in, rk22_in, rk23_in,
  input  logic [31:0] rk24_in, rk25_in, rk26_in, rk27_in,
  input  logic [31:0] rk28_in, rk29_in, rk30_in, rk31_in,
  sm4_round_engine_if.slave bus
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
    $error("sm4_round_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [4:0] LAST_CNT = 5'(32 - ROUNDS_PER_CYCLE);
  localparam logic [4:0] CNT_STEP = 5'(ROUNDS_PER_CYCLE);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef enum logic {S_IDLE, S_ROUND} state_t;

  state_t       state_q;
  logic [4:0]   round_cnt_q;
  logic [127:0] work_q;
  logic [127:0] data_out_q;
  logic         data_valid_q;
  logic         busy_q;

  logic [31:0]  rk [32];
  logic [127:0] x_chain [ROUNDS_PER_CYCLE+1];
  logic         ready;
  logic         abort;

  // T = L(tau(A))
  function automatic logic [31:0] t_xform(input logic [31:0] a);
    logic [31:0] b;
    b = '0;
    for (int k = 0; k < 4; k++) b[8*k +: 8] = SBOX[a[8*k +: 8]];
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  // {Xi, Xi+1, Xi+2, Xi+3} -> {Xi+1, Xi+2, Xi+3, Xi+4}
  function automatic logic [127:0] sm4_round(input logic [127:0] x, input logic [31:0] rk_i);
    return {x[95:0], x[127:96] ^ t_xform(x[95:64] ^ x[63:32] ^ x[31:0] ^ rk_i)};
  endfunction

  assign rk = '{rk00_in, rk01_in, rk02_in, rk03_in, rk04_in, rk05_in, rk06_in, rk07_in,
                rk08_in, rk09_in, rk10_in, rk11_in, rk12_in, rk13_in, rk14_in, rk15_in,
                rk16_in, rk17_in, rk18_in, rk19_in, rk20_in, rk21_in, rk22_in, rk23_in,
                rk24_in, rk25_in, rk26_in, rk27_in, rk28_in, rk29_in, rk30_in, rk31_in};

  assign x_chain[0] = work_q;
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    logic [4:0] rk_idx;
    assign rk_idx       = round_cnt_q + 5'(g);
    assign x_chain[g+1] = sm4_round(x_chain[g], rk[rk_idx]);
  end

  assign ready = (state_q == S_IDLE) && sm4_enable_in && key_exp_finished_in;
  assign abort = !sm4_enable_in || !key_exp_finished_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      round_cnt_q  <= '0;
      work_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.data_valid_in && ready) begin
            state_q     <= S_ROUND;
            busy_q      <= 1'b1;
            work_q      <= bus.data_in;
            round_cnt_q <= '0;
          end
        end
        S_ROUND: begin
          // abort wins over completion on the final edge
          if (abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            round_cnt_q <= '0;
          end else if (round_cnt_q == LAST_CNT) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            round_cnt_q  <= '0;
            work_q       <= x_chain[ROUNDS_PER_CYCLE];
            data_out_q   <= {x_chain[ROUNDS_PER_CYCLE][31:0],  x_chain[ROUNDS_PER_CYCLE][63:32],
                             x_chain[ROUNDS_PER_CYCLE][95:64], x_chain[ROUNDS_PER_CYCLE][127:96]};
            data_valid_q <= 1'b1;
          end else begin
            work_q      <= x_chain[ROUNDS_PER_CYCLE];
            round_cnt_q <= round_cnt_q + CNT_STEP;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_out      = ready;
  assign bus.busy_out       = busy_q;
  assign bus.data_out       = data_out_q;
  assign bus.data_valid_out = data_valid_q;

endmodule

// File: tb/tb_sm4_round_engine.sv
module tb_sm4_round_engine;

  localparam logic [127:0] KAT_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KAT_CT  = 128'h681edf34d206965e86b3e94f536e4246;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sm4_enable;
  logic        key_fin;
  logic [31:0] rk_tb [32];

  int tests = 0;
  int fails = 0;
  logic [127:0] last_out1;

  always #5 clk = ~clk;

  sm4_round_engine_if bus1 ();
  sm4_round_engine_if bus2 ();
  sm4_round_engine_if bus4 ();

  sm4_round_engine #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .sm4_enable_in(sm4_enable), .key_exp_finished_in(key_fin),
    .rk00_in(rk_tb[0]),  .rk01_in(rk_tb[1]),  .rk02_in(rk_tb[2]),  .rk03_in(rk_tb[3]),
    .rk04_in(rk_tb[4]),  .rk05_in(rk_tb[5]),  .rk06_in(rk_tb[6]),  .rk07_in(rk_tb[7]),
    .rk08_in(rk_tb[8]),  .rk09_in(rk_tb[9]),  .rk10_in(rk_tb[10]), .rk11_in(rk_tb[11]),
    .rk12_in(rk_tb[12]), .rk13_in(rk_tb[13]), .rk14_in(rk_tb[14]), .rk15_in(rk_tb[15]),
    .rk16_in(rk_tb[16]), .rk17_in(rk_tb[17]), .rk18_in(rk_tb[18]), .rk19_in(rk_tb[19]),
    .rk20_in(rk_tb[20]), .rk21_in(rk_tb[21]), .rk22_in(rk_tb[22]), .rk23_in(rk_tb[23]),
    .rk24_in(rk_tb[24]), .rk25_in(rk_tb[25]), .rk26_in(rk_tb[26]), .rk27_in(rk_tb[27]),
    .rk28_in(rk_tb[28]), .rk29_in(rk_tb[29]), .rk30_in(rk_tb[30]), .rk31_in(rk_tb[31]),
    .bus(bus1));

  sm4_round_engine #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .sm4_enable_in(sm4_enable), .key_exp_finished_in(key_fin),
    .rk00_in(rk_tb[0]),  .rk01_in(rk_tb[1]),  .rk02_in(rk_tb[2]),  .rk03_in(rk_tb[3]),
    .rk04_in(rk_tb[4]),  .rk05_in(rk_tb[5]),  .rk06_in(rk_tb[6]),  .rk07_in(rk_tb[7]),
    .rk08_in(rk_tb[8]),  .rk09_in(rk_tb[9]),  .rk10_in(rk_tb[10]), .rk11_in(rk_tb[11]),
    .rk12_in(rk_tb[12]), .rk13_in(rk_tb[13]), .rk14_in(rk_tb[14]), .rk15_in(rk_tb[15]),
    .rk16_in(rk_tb[16]), .rk17_in(rk_tb[17]), .rk18_in(rk_tb[18]), .rk19_in(rk_tb[19]),
    .rk20_in(rk_tb[20]), .rk21_in(rk_tb[21]), .rk22_in(rk_tb[22]), .rk23_in(rk_tb[23]),
    .rk24_in(rk_tb[24]), .rk25_in(rk_tb[25]), .rk26_in(rk_tb[26]), .rk27_in(rk_tb[27]),
    .rk28_in(rk_tb[28]), .rk29_in(rk_tb[29]), .rk30_in(rk_tb[30]), .rk31_in(rk_tb[31]),
    .bus(bus2));

  sm4_round_engine #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .sm4_enable_in(sm4_enable), .key_exp_finished_in(key_fin),
    .rk00_in(rk_tb[0]),  .rk01_in(rk_tb[1]),  .rk02_in(rk_tb[2]),  .rk03_in(rk_tb[3]),
    .rk04_in(rk_tb[4]),  .rk05_in(rk_tb[5]),  .rk06_in(rk_tb[6]),  .rk07_in(rk_tb[7]),
    .rk08_in(rk_tb[8]),  .rk09_in(rk_tb[9]),  .rk10_in(rk_tb[10]), .rk11_in(rk_tb[11]),
    .rk12_in(rk_tb[12]), .rk13_in(rk_tb[13]), .rk14_in(rk_tb[14]), .rk15_in(rk_tb[15]),
    .rk16_in(rk_tb[16]), .rk17_in(rk_tb[17]), .rk18_in(rk_tb[18]), .rk19_in(rk_tb[19]),
    .rk20_in(rk_tb[20]), .rk21_in(rk_tb[21]), .rk22_in(rk_tb[22]), .rk23_in(rk_tb[23]),
    .rk24_in(rk_tb[24]), .rk25_in(rk_tb[25]), .rk26_in(rk_tb[26]), .rk27_in(rk_tb[27]),
    .rk28_in(rk_tb[28]), .rk29_in(rk_tb[29]), .rk30_in(rk_tb[30]), .rk31_in(rk_tb[31]),
    .bus(bus4));

  // ---------------- reference model ----------------
  logic [7:0] sbox_m [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tsub(input logic [31:0] a);
    logic [31:0] b;
    b = '0;
    for (int k = 0; k < 4; k++) b[8*k +: 8] = sbox_m[a[8*k +: 8]];
    return b;
  endfunction

  // standard SM4 key schedule, returns encryption round key i
  function automatic logic [31:0] round_key(input logic [127:0] key, input int i);
    logic [31:0] k [36];
    logic [31:0] fk [4];
    logic [31:0] ck, b;
    fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    for (int j = 0; j < 4; j++) k[j] = key[127-32*j -: 32] ^ fk[j];
    for (int j = 0; j < 32; j++) begin
      ck = {8'((4*j)*7), 8'((4*j+1)*7), 8'((4*j+2)*7), 8'((4*j+3)*7)};
      b = tsub(k[j+1] ^ k[j+2] ^ k[j+3] ^ ck);
      k[j+4] = k[j] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
    end
    return k[i+4];
  endfunction

  function automatic logic [127:0] ref_cipher(input logic [127:0] key, input bit dec, input logic [127:0] blk);
    logic [31:0] x [36];
    logic [31:0] b;
    for (int j = 0; j < 4; j++) x[j] = blk[127-32*j -: 32];
    for (int i = 0; i < 32; i++) begin
      b = tsub(x[i+1] ^ x[i+2] ^ x[i+3] ^ round_key(key, dec ? 31 - i : i));
      x[i+4] = x[i] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic load_keys(input logic [127:0] key, input bit dec);
    key_fin = 1'b0;
    for (int i = 0; i < 32; i++) rk_tb[i] = round_key(key, dec ? 31 - i : i);
    key_fin = 1'b1;
  endtask

  function automatic logic rdy(input int d);
    case (d)
      1: return bus1.ready_out;
      2: return bus2.ready_out;
      default: return bus4.ready_out;
    endcase
  endfunction

  function automatic logic vld(input int d);
    case (d)
      1: return bus1.data_valid_out;
      2: return bus2.data_valid_out;
      default: return bus4.data_valid_out;
    endcase
  endfunction

  function automatic logic bsy(input int d);
    case (d)
      1: return bus1.busy_out;
      2: return bus2.busy_out;
      default: return bus4.busy_out;
    endcase
  endfunction

  function automatic logic [127:0] dout(input int d);
    case (d)
      1: return bus1.data_out;
      2: return bus2.data_out;
      default: return bus4.data_out;
    endcase
  endfunction

  task automatic set_in(input int d, input logic [127:0] din, input logic v);
    case (d)
      1: begin bus1.data_in = din; bus1.data_valid_in = v; end
      2: begin bus2.data_in = din; bus2.data_valid_in = v; end
      default: begin bus4.data_in = din; bus4.data_valid_in = v; end
    endcase
  endtask

  // Offer a block, wait for the accept edge; returns between E0 and E1 with
  // data_valid_in dropped unless keep is set.
  task automatic start_blk(input int d, input logic [127:0] din, input bit keep, input string nm, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    set_in(d, din, 1'b1);
    for (int c = 0; c < 8; c++) begin
      if (rdy(d)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      set_in(d, din, 1'b0);
      chk({nm, " accept"}, 128'(ok), 128'd1);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!keep) set_in(d, din, 1'b0);
  endtask

  // Wait for data_valid_out; lat = edges after accept edge (0 on timeout).
  task automatic wait_done(input int d, output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (vld(d)) begin lat = n; break; end
    end
  endtask

  task automatic run_blk(input int d, input logic [127:0] din, input logic [127:0] exp, input string nm);
    bit ok;
    int lat;
    start_blk(d, din, 1'b0, nm, ok);
    if (!ok) return;
    wait_done(d, lat);
    chk({nm, " latency"}, 128'(lat), 128'(32 / d));
    chk({nm, " data"}, dout(d), exp);
    @(negedge clk);
    chk({nm, " pulse width"}, 128'(vld(d)), 128'd0);
    if (d == 1 && lat != 0) last_out1 = exp;
  endtask

  typedef struct {
    logic [127:0] key;
    bit           dec;
    logic [127:0] din;
    logic [127:0] exp;
    string        nm;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [127:0] k, p, a_blk, b_blk;
    bit ok;
    int lat, cnt_v, cnt_r, cnt_b;

    k = rnd128();
    p = rnd128();
    vecs[0].key = KAT_KEY; vecs[0].dec = 1'b0; vecs[0].din = KAT_KEY; vecs[0].exp = KAT_CT;  vecs[0].nm = "enc_kat";
    vecs[1].key = KAT_KEY; vecs[1].dec = 1'b1; vecs[1].din = KAT_CT;  vecs[1].exp = KAT_KEY; vecs[1].nm = "dec_kat";
    vecs[2].key = k; vecs[2].dec = 1'b0; vecs[2].din = p; vecs[2].exp = ref_cipher(k, 1'b0, p); vecs[2].nm = "enc_rnd";
    vecs[3].key = k; vecs[3].dec = 1'b1; vecs[3].din = vecs[2].exp; vecs[3].exp = p; vecs[3].nm = "dec_roundtrip";

    reset_n = 1'b0;
    sm4_enable = 1'b1;
    key_fin = 1'b0;
    for (int i = 0; i < 32; i++) rk_tb[i] = '0;
    set_in(1, '0, 1'b0);
    set_in(2, '0, 1'b0);
    set_in(4, '0, 1'b0);
    last_out1 = '0;

    #12;
    chk("reset data_out", dout(1), 128'd0);
    chk("reset data_valid_out", 128'(vld(1)), 128'd0);
    chk("reset busy_out", 128'(bsy(1)), 128'd0);
    chk("reset ready_out (keys not ready)", 128'(rdy(1)), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // table vectors, R = 1
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      load_keys(vecs[v].key, vecs[v].dec);
      run_blk(1, vecs[v].din, vecs[v].exp, vecs[v].nm);
    end

    // randomized blocks against the reference model
    for (int r = 0; r < 5; r++) begin
      bit dec;
      k = rnd128();
      p = rnd128();
      dec = 1'($urandom_range(0, 1));
      @(negedge clk);
      load_keys(k, dec);
      run_blk(1, p, ref_cipher(k, dec, p), $sformatf("rand%0d", r));
    end

    // back-to-back with data_valid_in held high
    @(negedge clk);
    load_keys(KAT_KEY, 1'b0);
    a_blk = KAT_KEY;
    b_blk = rnd128();
    start_blk(1, a_blk, 1'b1, "b2b first", ok);
    if (ok) begin
      set_in(1, b_blk, 1'b1);
      cnt_r = 0;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (vld(1)) begin lat = n; break; end
        if (rdy(1)) cnt_r++;
      end
      chk("b2b ready during ROUND", 128'(cnt_r), 128'd0);
      chk("b2b first latency", 128'(lat), 128'd32);
      chk("b2b first data", dout(1), KAT_CT);
      chk("b2b ready at pulse", 128'(rdy(1)), 128'd1);
      @(negedge clk);
      chk("b2b second accepted next edge", 128'(bsy(1)), 128'd1);
      set_in(1, b_blk, 1'b0);
      wait_done(1, lat);
      chk("b2b second latency", 128'(lat), 128'd32);
      chk("b2b second data", dout(1), ref_cipher(KAT_KEY, 1'b0, b_blk));
      last_out1 = ref_cipher(KAT_KEY, 1'b0, b_blk);
    end

    // key not ready: request must be ignored
    @(negedge clk);
    key_fin = 1'b0;
    set_in(1, rnd128(), 1'b1);
    cnt_r = 0; cnt_b = 0; cnt_v = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (rdy(1)) cnt_r++;
      if (bsy(1)) cnt_b++;
      if (vld(1)) cnt_v++;
    end
    chk("keys not ready: ready_out", 128'(cnt_r), 128'd0);
    chk("keys not ready: no accept", 128'(cnt_b + cnt_v), 128'd0);
    set_in(1, '0, 1'b0);
    key_fin = 1'b1;

    // abort at round 10 via sm4_enable_in
    start_blk(1, rnd128(), 1'b0, "abort10", ok);
    if (ok) begin
      repeat (10) @(negedge clk);
      sm4_enable = 1'b0;
      cnt_v = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (vld(1)) cnt_v++;
      end
      chk("abort10 no valid", 128'(cnt_v), 128'd0);
      chk("abort10 busy", 128'(bsy(1)), 128'd0);
      chk("abort10 data_out held", dout(1), last_out1);
      sm4_enable = 1'b1;
      #1 chk("abort10 idle after re-enable", 128'(rdy(1)), 128'd1);
      run_blk(1, KAT_KEY, KAT_CT, "abort10 rerun");
    end

    // abort coinciding with the round-31 edge
    start_blk(1, rnd128(), 1'b0, "abort31", ok);
    if (ok) begin
      repeat (31) @(negedge clk);
      key_fin = 1'b0;
      cnt_v = 0;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        if (vld(1)) cnt_v++;
      end
      chk("abort31 no valid", 128'(cnt_v), 128'd0);
      chk("abort31 busy", 128'(bsy(1)), 128'd0);
      chk("abort31 data_out held", dout(1), last_out1);
      key_fin = 1'b1;
    end

    // unrolled engines
    for (int d = 2; d <= 4; d *= 2) begin
      @(negedge clk);
      load_keys(KAT_KEY, 1'b0);
      run_blk(d, KAT_KEY, KAT_CT, $sformatf("R%0d enc_kat", d));
      k = rnd128();
      p = rnd128();
      load_keys(k, 1'b1);
      run_blk(d, p, ref_cipher(k, 1'b1, p), $sformatf("R%0d dec_rnd", d));
    end

    // asynchronous reset in the middle of a block
    @(negedge clk);
    load_keys(KAT_KEY, 1'b0);
    start_blk(1, KAT_KEY, 1'b0, "reset mid-block", ok);
    if (ok) begin
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async reset data_out", dout(1), 128'd0);
      chk("async reset busy_out", 128'(bsy(1)), 128'd0);
      chk("async reset data_valid_out", 128'(vld(1)), 128'd0);
      chk("async reset R4 data_out", dout(4), 128'd0);
      @(negedge clk);
      reset_n = 1'b1;
      last_out1 = '0;
      run_blk(1, KAT_KEY, KAT_CT, "after reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
